// File: rtl/npu_quant_pkg.sv
// Shared constants and types for the requantisation datapath.
package npu_quant_pkg;

    // Width of the registered right-shift amount (i_q + w_q - o_q, signed 6-bit).
    localparam int unsigned SHIFT_W = 6;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,  // floor
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_HALF_AWAY = 2'd3
    } round_mode_e;

endpackage

// File: rtl/requant_round_array_lane.sv
// One lane of the requantiser: shift+round (stage-1 comb) and saturate+ReLU (stage-2 comb).
module requant_lane
    import npu_quant_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]    dat_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  round_mode_e        mode_i,
    output logic [IN_W:0]      rnd_o,
    input  logic [IN_W:0]      rnd_i,
    input  logic               relu_i,
    output logic [OUT_W-1:0]   res_o,
    output logic               clamp_o
);

    localparam int unsigned RW = IN_W + 1;
    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [SHIFT_W-1:0] s_eff;
    logic signed [IN_W:0] x_ext;
    logic signed [IN_W:0] q;
    logic [IN_W+1:0] one_w;
    logic [IN_W+1:0] mask;
    logic [IN_W+1:0] rem;
    logic [IN_W+1:0] half;
    logic gt_half;
    logic eq_half;
    logic inc;
    logic signed [IN_W:0] rnd_s;
    logic [OUT_W-1:0] sat;

    // Rounding is done as floor plus a mode-dependent increment from the discarded
    // remainder; this equals add-half-then-shift but stays exact for shifts beyond IN_W,
    // which are clamped to IN_W+1 (every result there is already 0 or -1).
    always_comb begin
        s_eff   = (shift_i > SHIFT_W'(RW)) ? SHIFT_W'(RW) : shift_i;
        x_ext   = {dat_i[IN_W-1], dat_i};
        q       = x_ext >>> s_eff;
        one_w   = (IN_W+2)'(1);
        mask    = (one_w << s_eff) - one_w;
        rem     = {1'b0, x_ext} & mask;
        half    = (s_eff == '0) ? '0 : (one_w << (s_eff - SHIFT_W'(1)));
        gt_half = (rem > half);
        eq_half = (rem == half);
        inc     = 1'b0;
        case (mode_i)
            RND_TRUNC:     inc = 1'b0;
            RND_HALF_UP:   inc = gt_half | eq_half;
            RND_HALF_EVEN: inc = gt_half | (eq_half & q[0]);
            RND_HALF_AWAY: inc = gt_half | (eq_half & ~x_ext[IN_W]);
            default:       inc = 1'b0;
        endcase
        rnd_o = (s_eff == '0) ? x_ext : (q + {{IN_W{1'b0}}, inc});
    end

    // Saturate the stage-1 value to OUT_W, then apply ReLU to the saturated result.
    always_comb begin
        rnd_s   = rnd_i;
        sat     = rnd_i[OUT_W-1:0];
        clamp_o = 1'b0;
        if (rnd_s > SAT_MAX) begin
            sat     = SAT_MAX[OUT_W-1:0];
            clamp_o = 1'b1;
        end else if (rnd_s < SAT_MIN) begin
            sat     = SAT_MIN[OUT_W-1:0];
            clamp_o = 1'b1;
        end
        res_o = (relu_i && sat[OUT_W-1]) ? '0 : sat;
    end

endmodule

// File: rtl/requant_round_array.sv
// Multi-lane requantiser: 2-stage valid/ready pipeline (shift+round, saturate+ReLU).
module requant_round_array
    import npu_quant_pkg::*;
#(
    parameter int LANES = 32,
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [3:0]             i_q_encode,
    input  logic [3:0]             w_q_encode,
    input  logic [3:0]             o_q_encode,
    input  logic                   i_cfg_load,
    input  logic [1:0]             i_round_mode,
    input  logic                   i_relu_en,
    input  logic                   i_dat_vld,
    output logic                   o_dat_rdy,
    input  logic [LANES*IN_W-1:0]  i_dat,
    output logic                   o_dat_vld,
    input  logic                   i_dat_rdy,
    output logic [LANES*OUT_W-1:0] o_dat,
    output logic                   o_cfg_err,
    input  logic                   i_cnt_clr,
    output logic [CNT_W-1:0]       o_sat_cnt
);

    localparam int CW1 = CNT_W + 1;

    logic [SHIFT_W-1:0] shift_q;
    round_mode_e        mode_q;
    logic               relu_q;
    logic               cfg_err_q, cfg_err_d;

    logic                        s1_vld_q;
    logic [LANES-1:0][IN_W:0]    s1_rnd_q;
    logic                        s2_vld_q;
    logic [LANES*OUT_W-1:0]      s2_dat_q;
    logic [LANES-1:0]            s2_clamp_q;
    logic [CNT_W-1:0]            sat_cnt_q, sat_cnt_d;

    logic [LANES-1:0][IN_W:0]    rnd_d;
    logic [LANES*OUT_W-1:0]      res_d;
    logic [LANES-1:0]            clamp_d;

    logic               in_xfer;
    logic               out_xfer;
    logic               s2_load_en;
    logic               cfg_accept;
    logic [SHIFT_W-1:0] shift_raw;
    logic [CW1-1:0]     clamp_num;
    logic [CW1-1:0]     cnt_sum;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        requant_lane #(
            .IN_W (IN_W),
            .OUT_W(OUT_W)
        ) u_lane (
            .dat_i  (i_dat[g*IN_W +: IN_W]),
            .shift_i(shift_q),
            .mode_i (mode_q),
            .rnd_o  (rnd_d[g]),
            .rnd_i  (s1_rnd_q[g]),
            .relu_i (relu_q),
            .res_o  (res_d[g*OUT_W +: OUT_W]),
            .clamp_o(clamp_d[g])
        );
    end

    assign o_dat_rdy  = i_dat_rdy || !s2_vld_q || !s1_vld_q;
    assign in_xfer    = i_dat_vld && o_dat_rdy;
    assign s2_load_en = !s2_vld_q || i_dat_rdy;
    assign out_xfer   = s2_vld_q && i_dat_rdy;
    assign cfg_accept = i_cfg_load && !s1_vld_q && !s2_vld_q;
    assign shift_raw  = SHIFT_W'(i_q_encode) + SHIFT_W'(w_q_encode) - SHIFT_W'(o_q_encode);

    assign o_dat_vld = s2_vld_q;
    assign o_dat     = s2_dat_q;
    assign o_cfg_err = cfg_err_q;
    assign o_sat_cnt = sat_cnt_q;

    // Next values for the saturation counter and the sticky config error; clear has priority.
    always_comb begin
        clamp_num = '0;
        for (int unsigned k = 0; k < unsigned'(LANES); k++) begin
            clamp_num = clamp_num + CW1'(clamp_d_sel(k));
        end
        cnt_sum   = {1'b0, sat_cnt_q} + clamp_num;
        sat_cnt_d = sat_cnt_q;
        if (i_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (out_xfer) begin
            sat_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
        cfg_err_d = cfg_err_q;
        if (i_cnt_clr) begin
            cfg_err_d = 1'b0;
        end else if (cfg_accept && shift_raw[SHIFT_W-1]) begin
            cfg_err_d = 1'b1;
        end
    end

    function automatic logic clamp_d_sel(input int unsigned k);
        return s2_clamp_q[k];
    endfunction

    // Configuration register: only loads while both stages are empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            mode_q  <= RND_TRUNC;
            relu_q  <= 1'b0;
        end else if (cfg_accept) begin
            shift_q <= shift_raw[SHIFT_W-1] ? '0 : shift_raw;
            mode_q  <= round_mode_e'(i_round_mode);
            relu_q  <= i_relu_en;
        end
    end

    // Stage 1: capture the rounded lanes whenever the stage may advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld_q <= 1'b0;
            s1_rnd_q <= '0;
        end else if (o_dat_rdy) begin
            s1_vld_q <= in_xfer;
            if (in_xfer) begin
                s1_rnd_q <= rnd_d;
            end
        end
    end

    // Stage 2 / output register: holds steady while the consumer stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld_q   <= 1'b0;
            s2_dat_q   <= '0;
            s2_clamp_q <= '0;
        end else if (s2_load_en) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_dat_q   <= res_d;
                s2_clamp_q <= clamp_d;
            end
        end
    end

    // Saturation counter and sticky configuration error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sat_cnt_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule
